// File: rtl/gv_game_pkg.sv
// Shared game definitions used by the score sequencer, high-score and display logic.
//   mode_t  : game state encoding driven onto the mode bus
//   SCORE_W : width of the per-song score
package gv_game_pkg;
  localparam int SCORE_W = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    COUNTDOWN = 3'b001,
    PLAY      = 3'b010,
    PAUSE     = 3'b011,
    FINISH    = 3'b101
  } mode_t;
endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with a zero flag; also intended for note spawn timing.
//   clk, n_rst : clock, async active-low reset
//   load       : load the counter with load_val (has priority over en)
//   en         : decrement by one per cycle, stopping at zero
//   load_val   : value loaded on load
//   zero       : counter currently reads zero
module countdown_timer #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                 cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (en && cnt != '0)   cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/score_sequencer.sv
// Game flow sequencer: IDLE -> COUNTDOWN -> PLAY (-> PAUSE) -> FINISH -> IDLE.
// Counts hits (saturating score), misses and remaining notes, and pulses
// commit on the cycle the final score first appears with mode FINISH.
// Build option: define SCORE_SEQ_PAUSE_EN to include the PAUSE state.
//   clk, n_rst                 : clock, async active-low reset
//   start, pause               : one-cycle control pulses
//   hit, miss, note_done       : one-cycle gameplay pulses (used only in PLAY)
//   mode                       : registered game state encoding
//   score                      : registered song score
//   commit                     : registered one-cycle "score is final" pulse
module score_sequencer
  import gv_game_pkg::*;
#(
  parameter int unsigned COUNTDOWN_CYCLES = 36_000_000,
  parameter int unsigned SONG_NOTES       = 16,
  parameter int unsigned MAX_MISS         = 4
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic               pause,
  input  logic               hit,
  input  logic               miss,
  input  logic               note_done,
  output logic [2:0]         mode,
  output logic [SCORE_W-1:0] score,
  output logic               commit
);
  localparam int CD_W = (COUNTDOWN_CYCLES > 1) ? $clog2(COUNTDOWN_CYCLES) : 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  mode_t              state, state_n;
  logic [SCORE_W-1:0] score_n;
  logic [3:0]         miss_cnt, miss_n;
  logic [7:0]         notes_left, notes_n;
  logic               commit_n;
  logic               cd_load, cd_zero;

`ifndef SCORE_SEQ_PAUSE_EN
  logic unused_pause;
  assign unused_pause = pause;
`endif

  countdown_timer #(.W(CD_W)) u_cd (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (cd_load),
    .en       (state == COUNTDOWN),
    .load_val (CD_W'(COUNTDOWN_CYCLES - 1)),
    .zero     (cd_zero)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      score      <= '0;
      miss_cnt   <= '0;
      notes_left <= '0;
      commit     <= 1'b0;
    end else begin
      state      <= state_n;
      score      <= score_n;
      miss_cnt   <= miss_n;
      notes_left <= notes_n;
      commit     <= commit_n;
    end
  end

  always_comb begin
    state_n = state;
    score_n = score;
    miss_n  = miss_cnt;
    notes_n = notes_left;
    cd_load = 1'b0;
    case (state)
      IDLE: begin
        score_n = '0;
        if (start) begin
          state_n = COUNTDOWN;
          cd_load = 1'b1;
        end
      end
      COUNTDOWN: begin
        if (cd_zero) begin
          state_n = PLAY;
          notes_n = 8'(SONG_NOTES);
          miss_n  = '0;
          score_n = '0;
        end
      end
      PLAY: begin
        // hit wins over a simultaneous miss; the miss is dropped entirely
        if (hit) begin
          if (score != SCORE_MAX) score_n = score + SCORE_W'(1);
        end else if (miss) begin
          miss_n = miss_cnt + 4'd1;
        end
        if (note_done) notes_n = notes_left - 8'd1;
        // finishing takes priority over a coincident pause
        if ((note_done && notes_left == 8'd1) ||
            (!hit && miss && miss_n == 4'(MAX_MISS)))
          state_n = FINISH;
`ifdef SCORE_SEQ_PAUSE_EN
        else if (pause)
          state_n = PAUSE;
`endif
      end
`ifdef SCORE_SEQ_PAUSE_EN
      PAUSE: begin
        if (pause) state_n = PLAY;
      end
`endif
      FINISH: begin
        if (start) begin
          state_n = IDLE;
          score_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
    commit_n = (state_n == FINISH) && (state != FINISH);
  end

  assign mode = state;
endmodule

// File: tb/tb_score_sequencer.sv
module tb_score_sequencer;
  logic       clk = 1'b0;
  logic       n_rst;
  logic       start, pause, hit, miss, note_done;
  logic [2:0] mode;
  logic [3:0] score;
  logic       commit;
  int         tests = 0;
  int         fails = 0;

  score_sequencer #(
    .COUNTDOWN_CYCLES(3),
    .SONG_NOTES      (4),
    .MAX_MISS        (2)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .pause     (pause),
    .hit       (hit),
    .miss      (miss),
    .note_done (note_done),
    .mode      (mode),
    .score     (score),
    .commit    (commit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // apply one-cycle pulses, clock once, sample 1 time unit after the edge
  task automatic pulse(input logic s, p, h, m, nd);
    start = s; pause = p; hit = h; miss = m; note_done = nd;
    @(posedge clk); #1;
    start = 0; pause = 0; hit = 0; miss = 0; note_done = 0;
  endtask

  task automatic idle();
    pulse(0, 0, 0, 0, 0);
  endtask

  task automatic expect3(input string tag, input logic [2:0] m, input logic [3:0] s,
                         input logic c);
    chk({tag, ".mode"}, {1'b0, mode}, {1'b0, m});
    chk({tag, ".score"}, score, s);
    chk({tag, ".commit"}, {3'b0, commit}, {3'b0, c});
  endtask

  task automatic to_play(input string tag);
    pulse(1, 0, 0, 0, 0);
    pulse(0, 0, 1, 0, 1);  // gameplay pulses in COUNTDOWN must be ignored
    idle();
    idle();
    expect3(tag, 3'b010, 4'd0, 1'b0);
  endtask

  initial begin
    n_rst = 0; start = 0; pause = 0; hit = 0; miss = 0; note_done = 0;
    repeat (2) @(posedge clk);
    #1;
    expect3("reset", 3'b000, 4'd0, 1'b0);
    n_rst = 1;
    idle();
    expect3("idle", 3'b000, 4'd0, 1'b0);
    pulse(0, 1, 1, 1, 1);
    expect3("idle_ignore", 3'b000, 4'd0, 1'b0);

    // Scenario 1: countdown lasts exactly 3 cycles
    pulse(1, 0, 0, 0, 0);
    expect3("cd1", 3'b001, 4'd0, 1'b0);
    idle();
    expect3("cd2", 3'b001, 4'd0, 1'b0);
    pulse(1, 0, 1, 0, 0);
    expect3("cd3", 3'b001, 4'd0, 1'b0);
    idle();
    expect3("play", 3'b010, 4'd0, 1'b0);

    // Scenario 2: four hit+note_done notes, start ignored mid-song
    pulse(0, 0, 1, 0, 1);
    expect3("n1", 3'b010, 4'd1, 1'b0);
    pulse(1, 0, 1, 0, 1);
    expect3("n2", 3'b010, 4'd2, 1'b0);
    pulse(0, 0, 1, 0, 1);
    expect3("n3", 3'b010, 4'd3, 1'b0);
    pulse(0, 0, 1, 0, 1);
    expect3("n4", 3'b101, 4'd4, 1'b1);
    pulse(0, 0, 1, 0, 0);
    expect3("fin_hold", 3'b101, 4'd4, 1'b0);
    idle();
    expect3("fin_hold2", 3'b101, 4'd4, 1'b0);
    pulse(1, 0, 0, 0, 0);
    expect3("fin_to_idle", 3'b000, 4'd0, 1'b0);

    // Scenario 3: saturation at 15
    to_play("s3");
    repeat (20) pulse(0, 0, 1, 0, 0);
    expect3("sat", 3'b010, 4'd15, 1'b0);
    repeat (3) pulse(0, 0, 0, 0, 1);
    expect3("sat_nd3", 3'b010, 4'd15, 1'b0);
    pulse(0, 0, 1, 0, 1);
    expect3("sat_fin", 3'b101, 4'd15, 1'b1);
    pulse(1, 0, 0, 0, 0);
    expect3("s3_idle", 3'b000, 4'd0, 1'b0);

    // Scenario 4a: one hit then two misses
    to_play("s4a");
    pulse(0, 0, 1, 0, 0);
    expect3("s4a_hit", 3'b010, 4'd1, 1'b0);
    pulse(0, 0, 0, 1, 0);
    expect3("s4a_m1", 3'b010, 4'd1, 1'b0);
    pulse(0, 0, 0, 1, 0);
    expect3("s4a_m2", 3'b101, 4'd1, 1'b1);
    pulse(1, 0, 0, 0, 0);

    // Scenario 4b: hit+miss counts only the hit, so two further misses are needed
    to_play("s4b");
    pulse(0, 0, 1, 1, 0);
    expect3("s4b_hm", 3'b010, 4'd1, 1'b0);
    pulse(0, 0, 0, 1, 0);
    expect3("s4b_m1", 3'b010, 4'd1, 1'b0);
    pulse(0, 0, 0, 1, 0);
    expect3("s4b_m2", 3'b101, 4'd1, 1'b1);
    pulse(1, 0, 0, 0, 0);

    // Scenario 5: pause
    to_play("s5");
    pulse(0, 0, 1, 0, 0);
    expect3("s5_hit", 3'b010, 4'd1, 1'b0);
`ifdef SCORE_SEQ_PAUSE_EN
    pulse(0, 1, 0, 0, 0);
    expect3("s5_pause", 3'b011, 4'd1, 1'b0);
    repeat (3) pulse(0, 0, 1, 0, 1);
    expect3("s5_frozen", 3'b011, 4'd1, 1'b0);
    pulse(0, 1, 0, 0, 0);
    expect3("s5_resume", 3'b010, 4'd1, 1'b0);
    pulse(0, 0, 1, 0, 1);
    expect3("s5_n1", 3'b010, 4'd2, 1'b0);
    pulse(0, 0, 0, 0, 1);
    pulse(0, 0, 0, 0, 1);
    expect3("s5_n3", 3'b010, 4'd2, 1'b0);
    pulse(0, 1, 0, 0, 1);
    expect3("s5_fin_wins", 3'b101, 4'd2, 1'b1);
`else
    pulse(0, 1, 0, 0, 0);
    expect3("s5_nopause", 3'b010, 4'd1, 1'b0);
    pulse(0, 0, 1, 0, 1);
    expect3("s5_after", 3'b010, 4'd2, 1'b0);
    repeat (3) pulse(0, 1, 0, 0, 1);
    expect3("s5_fin", 3'b101, 4'd2, 1'b1);
`endif
    pulse(1, 0, 0, 0, 0);
    expect3("s5_idle", 3'b000, 4'd0, 1'b0);

    // Scenario 6: asynchronous reset mid-song with score 3
    to_play("s6");
    repeat (3) pulse(0, 0, 1, 0, 0);
    expect3("s6_pre", 3'b010, 4'd3, 1'b0);
    #2 n_rst = 0;
    #1;
    expect3("s6_async", 3'b000, 4'd0, 1'b0);
    pulse(0, 0, 1, 0, 1);
    expect3("s6_held", 3'b000, 4'd0, 1'b0);
    n_rst = 1;
    pulse(0, 0, 0, 0, 1);
    expect3("s6_after", 3'b000, 4'd0, 1'b0);
    pulse(1, 0, 0, 0, 0);
    expect3("s6_restart", 3'b001, 4'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/score_sequencer.md
SCORE_SEQUENCER -- requirements
Module: score_sequencer

Interface
REQ-001 The block SHALL take parameter COUNTDOWN_CYCLES, default 36_000_000, clk cycles spent in COUNTDOWN (3 s at 12 MHz).
REQ-002 The block SHALL take parameter SONG_NOTES, default 16, notes per song (range 1..255).
REQ-003 The block SHALL take parameter MAX_MISS, default 4, misses that end the song early (range 1..15).
REQ-004 Port: clk  input  1  system clock, 12 MHz, rising-edge.
REQ-005 Port: n_rst  input  1  asynchronous active-low reset.
REQ-006 Port: start  input  1  one-cycle pulse, start button (already synchronised and edge-detected).
REQ-007 Port: pause  input  1  one-cycle pulse, pause toggle.
REQ-008 Port: hit  input  1  one-cycle pulse, correct note played.
REQ-009 Port: miss  input  1  one-cycle pulse, note missed or wrong.
REQ-010 Port: note_done  input  1  one-cycle pulse, a note left the strike window.
REQ-011 Port: mode  output  3  game state encoding, consumed by high-score and display logic.
REQ-012 Port: score  output  4  current song score.
REQ-013 Port: commit  output  1  one-cycle pulse telling high-score logic that score is final.

Function
REQ-014 States and mode encodings SHALL be: IDLE 3'b000, COUNTDOWN 3'b001, PLAY 3'b010, PAUSE 3'b011, FINISH 3'b101.
REQ-015 All outputs SHALL be registered. Inputs are sampled on the rising edge of clk, and the outputs reflect them after that same edge.
REQ-016 IDLE: score held at 0. start SHALL move to COUNTDOWN and load the countdown counter with COUNTDOWN_CYCLES-1.
REQ-017 COUNTDOWN: the counter SHALL decrement each cycle. At 0 the block SHALL enter PLAY on the next edge, loading notes_left=SONG_NOTES and clearing miss_cnt and score.
REQ-018 PLAY hit: score SHALL increment by 1 and saturate at 15 (no wrap).
REQ-019 PLAY miss: miss_cnt SHALL increment. If hit and miss occur in the same cycle, hit SHALL take priority and miss SHALL be ignored.
REQ-020 PLAY note_done: notes_left SHALL decrement.
REQ-021 PLAY SHALL go to FINISH when note_done arrives with notes_left==1, or when an accepted miss makes miss_cnt reach MAX_MISS.
REQ-022 If hit coincides with the final note_done, the hit SHALL be counted before the score freezes.
REQ-023 commit SHALL pulse high for exactly the one cycle in which mode first reads FINISH.
REQ-024 FINISH: score SHALL be held. start SHALL return the block to IDLE, with score cleared on that edge.
REQ-025 start SHALL be ignored in COUNTDOWN, PLAY and PAUSE.
REQ-026 pause SHALL be ignored outside PLAY and PAUSE.
REQ-027 hit, miss and note_done SHALL be ignored outside PLAY.

Reset
REQ-028 When n_rst is low, the block SHALL asynchronously force state IDLE, mode=3'b000, score=0, commit=0, and all counters to 0.
REQ-029 Reset asserted mid-song SHALL abandon the song with no commit pulse.
REQ-030 Deassertion SHALL take effect on the first clk edge with n_rst high.

Configuration
REQ-031 With macro SCORE_SEQ_PAUSE_EN defined:
- pause in PLAY SHALL go to PAUSE; pause in PAUSE SHALL return to PLAY.
- Counters SHALL be frozen while in PAUSE.
- If pause coincides with the final note_done, FINISH SHALL win.
REQ-032 Without SCORE_SEQ_PAUSE_EN, the PAUSE state and its logic SHALL be absent and pause SHALL be ignored. The mode value 3'b011 SHALL never appear.

Structure
REQ-033 A shared package gv_game_pkg SHALL hold:
- the mode_t enum with the encodings of REQ-014 (FINISH=3'b101, shared with the high-score logic);
- the SCORE_W=4 constant.
REQ-034 The countdown SHALL be a sub-module, countdown_timer (load, enable, count value, zero flag), that is reusable for note spawn timing.

Verification
All scenarios use COUNTDOWN_CYCLES=3, SONG_NOTES=4, MAX_MISS=2.
REQ-035 Scenario 1: reset, then start -> mode=001 for 3 cycles, then 010, with score=0.
REQ-036 Scenario 2: 4 notes each with hit plus note_done -> score=4, mode=101, commit high for 1 cycle only.
REQ-037 Scenario 3: 20 hits before the last note_done -> score stays 15 (saturation), then FINISH.
REQ-038 Scenario 4: 2 misses after 1 hit -> FINISH with score=1; a hit plus miss in the same cycle counts only the hit.
REQ-039 Scenario 5: with PAUSE_EN, pause, then hit/note_done x3, then pause -> mode=011 and score unchanged during the pause, then mode=010 after it.
REQ-040 Scenario 6: n_rst low during PLAY with score=3 -> mode=000, score=0, no commit; start from FINISH -> IDLE with score=0.
